// File: rtl/uart_cal_pkg.sv
// ============================================================================
// Module : uart_cal_pkg
// Brief  : Shared ASCII constants, opcode encodings and decoder FSM states
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_cal_pkg;

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] ASCII_I = 8'h49;
    localparam logic [7:0] EQUAL   = 8'h3D;
    localparam logic [7:0] PLUS    = 8'h2B;
    localparam logic [7:0] MINUS   = 8'h2D;
    localparam logic [7:0] MUL     = 8'h2A;
    localparam logic [7:0] DIV     = 8'h2F;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef logic [2:0] dec_state_t;
    localparam dec_state_t ST_IDLE  = 3'd0;
    localparam dec_state_t ST_DATA1 = 3'd1;
    localparam dec_state_t ST_OPER  = 3'd2;
    localparam dec_state_t ST_DATA2 = 3'd3;
    localparam dec_state_t ST_EQ    = 3'd4;

    function automatic logic is_op(input logic [7:0] b);
        return (b == PLUS) || (b == MINUS) || (b == MUL) || (b == DIV);
    endfunction

    function automatic logic [1:0] op_encode(input logic [7:0] b);
        logic [1:0] r;
        case (b)
            MINUS:   r = OP_SUB;
            MUL:     r = OP_MUL;
            DIV:     r = OP_DIV;
            default: r = OP_ADD;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_decoder_ascii2hex.sv
// ============================================================================
// Module : ascii2hex
// Brief  : Combinational ASCII to hex-nibble converter; LOWERCASE_HEX_EN
//          additionally accepts 'a'-'f'.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ascii2hex (
    input  logic [7:0] ascii_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = ascii_i[3:0];
        end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
            // 'A' has low nibble 1, so +9 maps it to 10
            is_hex_o = 1'b1;
            nibble_o = ascii_i[3:0] + 4'd9;
        end
`ifdef LOWERCASE_HEX_EN
        else if (ascii_i >= 8'h61 && ascii_i <= 8'h66) begin
            is_hex_o = 1'b1;
            nibble_o = ascii_i[3:0] + 4'd9;
        end
`else
        else begin
            is_hex_o = 1'b0;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module : uart_cmd_decoder
// Brief  : Parses "I hhhh op hhhh =" ASCII frames into two operands and an
//          opcode. Optional macro LOWERCASE_HEX_EN accepts 'a'-'f' digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder
    import uart_cal_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SRC_W  = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [SRC_W-1:0] src1,
    output logic [SRC_W-1:0] src2,
    output logic [1:0]       op,
    output logic             dec_valid,
    output logic             dec_err
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0] sh1_q, sh1_d;
    logic [SRC_W-1:0] sh2_q, sh2_d;
    logic [1:0]       op_sh_q, op_sh_d;
    logic [SRC_W-1:0] src1_q, src1_d;
    logic [SRC_W-1:0] src2_q, src2_d;
    logic [1:0]       op_q, op_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             is_hex;
    logic [3:0]       nibble;
    logic             byte_act;
    logic             last_digit;

    ascii2hex u_ascii2hex (
        .ascii_i  (rx_data),
        .is_hex_o (is_hex),
        .nibble_o (nibble)
    );

    assign byte_act   = rx_valid && (rx_data != SPACE);
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_act) begin
            if (rx_data == ASCII_I) begin
                state_d = ST_DATA1;
            end else begin
                case (state_q)
                    ST_IDLE:  state_d = ST_IDLE;
                    ST_DATA1: state_d = !is_hex ? ST_IDLE : (last_digit ? ST_OPER : ST_DATA1);
                    ST_OPER:  state_d = is_op(rx_data) ? ST_DATA2 : ST_IDLE;
                    ST_DATA2: state_d = !is_hex ? ST_IDLE : (last_digit ? ST_EQ : ST_DATA2);
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Datapath and pulse outputs; src/op move only on a completed frame
    always_comb begin
        cnt_d   = cnt_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        op_sh_d = op_sh_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        op_d    = op_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (byte_act) begin
            if (rx_data == ASCII_I) begin
                cnt_d   = '0;
                sh1_d   = '0;
                sh2_d   = '0;
                op_sh_d = '0;
            end else begin
                case (state_q)
                    ST_DATA1: begin
                        if (is_hex) begin
                            sh1_d = {sh1_q[SRC_W-5:0], nibble};
                            cnt_d = last_digit ? '0 : cnt_q + CNT_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_OPER: begin
                        if (is_op(rx_data)) begin
                            op_sh_d = op_encode(rx_data);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_DATA2: begin
                        if (is_hex) begin
                            sh2_d = {sh2_q[SRC_W-5:0], nibble};
                            cnt_d = last_digit ? '0 : cnt_q + CNT_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_EQ: begin
                        if (rx_data == EQUAL) begin
                            src1_d  = sh1_q;
                            src2_d  = sh2_q;
                            op_d    = op_sh_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                        err_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            op_sh_q <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            op_sh_q <= op_sh_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign src1      = src1_q;
    assign src2      = src2_q;
    assign op        = op_q;
    assign dec_valid = valid_q;
    assign dec_err   = err_q;

endmodule

`default_nettype wire

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Receive-side ASCII command parser for the UART calculator.
- Consumes bytes from the UART receiver (rx_data/rx_valid) and assembles frames of the form "I hhhh op hhhh =" into two operands and an opcode.
- Hands the operands and opcode to the ALU with a one-cycle valid pulse.
- Mirror of the result encoder on the transmit side.

Parameters:
- DIGITS, 4, hex digits per operand.
- SRC_W, 16, operand width in bits; must equal 4*DIGITS.

Ports:
- clk  input  1  system clock; single clock domain.
- n_rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received ASCII byte; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- src1  output  SRC_W  first operand; registered.
- src2  output  SRC_W  second operand; registered.
- op  output  2  opcode: 0='+' (0x2B), 1='-' (0x2D), 2='*' (0x2A), 3='/' (0x2F).
- dec_valid  output  1  one-cycle pulse: src1/src2/op hold a new complete frame.
- dec_err  output  1  one-cycle pulse: malformed frame discarded.

Behaviour:
- Interface: one clock, clk. Reset n_rst is asynchronous and active-low. Reset values: src1=0, src2=0, op=0, dec_valid=0, dec_err=0, FSM=IDLE, digit counter=0, shadow registers=0.
- Bytes are acted on only in cycles with rx_valid=1. With rx_valid=0, all state holds and dec_valid/dec_err are 0.
- Space (0x20) is ignored in every state: no state, counter or shadow change.
- Hex digits accepted: 0x30-0x39 -> 0-9, 0x41-0x46 -> A-F. Anything else is non-hex.
- FSM states: IDLE, DATA1, OPER, DATA2, EQ.
  - IDLE: 'I' (0x49) -> DATA1, clear counter and shadows. Any other non-space byte is silently dropped (no dec_err).
  - DATA1: hex digit -> shadow1 = {shadow1[SRC_W-5:0], nibble}, counter+1. When the DIGITS-th digit is accepted -> OPER, counter=0.
  - OPER: '+', '-', '*' or '/' -> latch op_shadow, go to DATA2.
  - DATA2: same as DATA1 using shadow2. After DIGITS digits -> EQ.
  - EQ: '=' (0x3D) -> on the same clock edge, src1<=shadow1, src2<=shadow2, op<=op_shadow, dec_valid<=1 for exactly one cycle, FSM -> IDLE.
- Latency: dec_valid is high in the cycle immediately following the edge that sampled '='.
- Outputs src1/src2/op change only on a successful frame. They hold between frames, including after errors.
- Error rule (states DATA1, OPER, DATA2, EQ): any byte other than space, the expected class, or 'I' -> dec_err=1 for one cycle, FSM -> IDLE, shadows are not copied to the outputs.
- Resync rule: 'I' in any non-IDLE state restarts the frame (-> DATA1, counter and shadows cleared) with no dec_err.
- Frames are never short: fewer than DIGITS digits before an op or '=' is an error. There is no implicit zero-padding.
- dec_valid and dec_err are never high in the same cycle.
- A byte arriving in the cycle right after dec_valid is processed normally from IDLE.
- Reset asserted mid-frame discards the partial frame; outputs return to reset values.

Optional Feature:
- Macro: LOWERCASE_HEX_EN.
- Defined: 0x61-0x66 ('a'-'f') are also accepted as hex digits 10-15.
- Undefined: those bytes are non-hex and trigger the error rule in DATA1/DATA2.

Decomposition:
- Shared package uart_cal_pkg holds:
  - ASCII constants: SPACE 0x20, ASCII_I 0x49, EQUAL 0x3D, PLUS 0x2B, MINUS 0x2D, MUL 0x2A, DIV 0x2F.
  - Opcode encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - FSM state encodings for this block.
- Sub-module ascii2hex: combinational, rx_data -> {is_hex, nibble[3:0]}. It contains the LOWERCASE_HEX_EN logic and is reusable by other ASCII parsers.

Test Plan:
- Frame "I1234+00FF=" (one byte per rx_valid, idle gaps) -> one dec_valid pulse; src1=0x1234, src2=0x00FF, op=0; dec_err stays 0.
- Frame "I 000A * BEEF =" with spaces -> src1=0x000A, src2=0xBEEF, op=2, one dec_valid pulse.
- "I12G4" -> dec_err pulse after 'G', no dec_valid; src1/src2/op keep prior values. A following "I0001/0002=" -> src1=1, src2=2, op=3.
- "I12I5678-0001=" (resync) -> no dec_err; src1=0x5678, src2=0x0001, op=1.
- n_rst pulsed after "I12" -> all outputs 0. A complete "I0003-0001=" then yields src1=3, src2=1, op=1.
- "Iabcd+0000=" -> with LOWERCASE_HEX_EN, src1=0xABCD with dec_valid. Without it, dec_err pulses on 'a' and there is no dec_valid.
